// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset CPU.
// Walks each instruction through 3-5 states and decodes datapath mux
// selects and write strobes from the current state (Moore style).
module mc_ctrl_fsm (
    input  logic       CLK,
    input  logic       rst,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       jal_link,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_retired,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        JALWB  = 4'd12,
        JR     = 4'd13,
        HALT   = 4'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_e state_q;
    state_e state_d;

    // The branch condition is resolved in the datapath, never in this block.
    logic unused_zero;
    assign unused_zero = zero;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: opcode dispatch in DECODE, lw/sw split in MEMADR.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  state_d = run ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = (funct == FN_JR) ? JR : EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    OP_JAL:       state_d = JALWB;
                    default:      state_d = HALT;
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, MEMWR, ALUWB, ADDIWB,
            BRANCH, JUMP, JALWB, JR: state_d = FETCH;
            HALT:   state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // Output decode from the current state; FETCH strobes are gated by run.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        jal_link      = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = run;
                pc_write  = run;
            end
            DECODE: begin
                alu_src_b = 2'b11;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            MEMWR: begin
                iord          = 1'b1;
                mem_write     = 1'b1;
                instr_retired = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_dst       = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            ADDIWB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
                instr_retired = 1'b1;
            end
            JUMP: begin
                pc_source     = 2'b10;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
            end
            JALWB: begin
                pc_source     = 2'b10;
                pc_write      = 1'b1;
                jal_link      = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            JR: begin
                pc_source     = 2'b11;
                pc_write      = 1'b1;
                instr_retired = 1'b1;
            end
            HALT: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;

    logic       CLK;
    logic       rst;
    logic       run;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       jal_link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_retired;
    logic       illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    mc_ctrl_fsm dut (
        .CLK(CLK), .rst(rst), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .iord(iord), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .jal_link(jal_link), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_retired(instr_retired), .illegal(illegal), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one cycle and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // All single-bit strobes other than the run-gated FETCH ones.
    function automatic logic [10:0] strobes();
        return {pc_write_cond, iord, mem_write, mem_to_reg, reg_dst, reg_write,
                jal_link, alu_src_a, instr_retired, illegal, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; opcode = 6'b100011; funct = 6'd0; zero = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL reset_state got=%0d exp=0", state);
        end
        n_checks++;
        if ({pc_write, ir_write} !== 2'b00 || strobes() !== 11'd0) begin
            n_fail++; $display("FAIL reset_strobes got pw=%b iw=%b s=%b exp all 0", pc_write, ir_write, strobes());
        end
        n_checks++;
        if (alu_src_b !== 2'b01 || alu_op !== 2'b00 || pc_source !== 2'b00) begin
            n_fail++; $display("FAIL reset_selects got b=%b op=%b ps=%b exp 01/00/00", alu_src_b, alu_op, pc_source);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL idle_no_run got=%0d exp=0", state);
        end
        run = 1'b1;
        #1;
        n_checks++;
        if ({pc_write, ir_write} !== 2'b11) begin
            n_fail++; $display("FAIL fetch_run_gate got=%b%b exp=11", pc_write, ir_write);
        end
        tick();
        n_checks++;
        if (state !== 4'd1) begin
            n_fail++; $display("FAIL run_to_decode got=%0d exp=1", state);
        end
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_lw();
        int exp_st [5];
        exp_st = '{0, 1, 2, 3, 4};
        opcode = 6'b100011; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (state !== 4'(exp_st[i]) || instr_retired !== (i == 4)) begin
                n_fail++; $display("FAIL lw_seq cyc=%0d got st=%0d ret=%b exp st=%0d ret=%b", i, state, instr_retired, exp_st[i], (i == 4));
            end
            if (i == 3) begin
                n_checks++;
                if (iord !== 1'b1 || reg_write !== 1'b0) begin
                    n_fail++; $display("FAIL lw_memrd got iord=%b rw=%b exp 1/0", iord, reg_write);
                end
            end
            if (i == 4) begin
                n_checks++;
                if (mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
                    n_fail++; $display("FAIL lw_memwb got m2r=%b rw=%b rd=%b exp 1/1/0", mem_to_reg, reg_write, reg_dst);
                end
            end
            tick();
        end
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL lw_return got=%0d exp=0", state);
        end
    endtask

    task automatic test_sw_rtype();
        int exp_sw [4];
        int exp_r  [4];
        exp_sw = '{0, 1, 2, 5};
        exp_r  = '{0, 1, 6, 7};
        opcode = 6'b101011; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (state !== 4'(exp_sw[i]) || mem_write !== (i == 3) || instr_retired !== (i == 3)) begin
                n_fail++; $display("FAIL sw_seq cyc=%0d got st=%0d mw=%b ret=%b exp st=%0d mw=ret=%b", i, state, mem_write, instr_retired, exp_sw[i], (i == 3));
            end
            tick();
        end
        opcode = 6'b000000; funct = 6'b100000;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (state !== 4'(exp_r[i])) begin
                n_fail++; $display("FAIL add_state cyc=%0d got=%0d exp=%0d", i, state, exp_r[i]);
            end
            if (i == 2) begin
                n_checks++;
                if (alu_op !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
                    n_fail++; $display("FAIL add_exec got op=%b a=%b b=%b exp 10/1/00", alu_op, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (reg_dst !== 1'b1 || reg_write !== 1'b1 || instr_retired !== 1'b1) begin
                    n_fail++; $display("FAIL add_wb got rd=%b rw=%b ret=%b exp 1/1/1", reg_dst, reg_write, instr_retired);
                end
            end
            tick();
        end
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL add_return got=%0d exp=0", state);
        end
    endtask

    task automatic test_branch_jumps();
        // beq, not taken
        opcode = 6'b000100; funct = 6'd0; zero = 1'b0; run = 1'b1;
        tick(); tick();
        n_checks++;
        if (state !== 4'd8 || pc_write_cond !== 1'b1 || pc_write !== 1'b0 || pc_source !== 2'b01 || alu_op !== 2'b01 || instr_retired !== 1'b1) begin
            n_fail++; $display("FAIL beq got st=%0d pwc=%b pw=%b ps=%b op=%b ret=%b exp 8/1/0/01/01/1", state, pc_write_cond, pc_write, pc_source, alu_op, instr_retired);
        end
        tick();
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL beq_cpi got=%0d exp=0", state);
        end
        // jal
        opcode = 6'b000011;
        tick(); tick();
        n_checks++;
        if (state !== 4'd12 || jal_link !== 1'b1 || reg_write !== 1'b1 || pc_write !== 1'b1 || pc_source !== 2'b10) begin
            n_fail++; $display("FAIL jal got st=%0d jl=%b rw=%b pw=%b ps=%b exp 12/1/1/1/10", state, jal_link, reg_write, pc_write, pc_source);
        end
        tick();
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL jal_cpi got=%0d exp=0", state);
        end
        // jr
        opcode = 6'b000000; funct = 6'b001000;
        tick(); tick();
        n_checks++;
        if (state !== 4'd13 || pc_source !== 2'b11 || pc_write !== 1'b1 || reg_write !== 1'b0) begin
            n_fail++; $display("FAIL jr got st=%0d ps=%b pw=%b rw=%b exp 13/11/1/0", state, pc_source, pc_write, reg_write);
        end
        tick();
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL jr_cpi got=%0d exp=0", state);
        end
        // j and addi
        opcode = 6'b000010; funct = 6'd0;
        tick(); tick();
        n_checks++;
        if (state !== 4'd11 || pc_source !== 2'b10 || pc_write !== 1'b1) begin
            n_fail++; $display("FAIL j got st=%0d ps=%b pw=%b exp 11/10/1", state, pc_source, pc_write);
        end
        tick();
        opcode = 6'b001000;
        tick(); tick();
        n_checks++;
        if (state !== 4'd9 || alu_src_a !== 1'b1 || alu_src_b !== 2'b10) begin
            n_fail++; $display("FAIL addi_ex got st=%0d a=%b b=%b exp 9/1/10", state, alu_src_a, alu_src_b);
        end
        tick();
        n_checks++;
        if (state !== 4'd10 || reg_write !== 1'b1 || reg_dst !== 1'b0 || instr_retired !== 1'b1) begin
            n_fail++; $display("FAIL addi_wb got st=%0d rw=%b rd=%b ret=%b exp 10/1/0/1", state, reg_write, reg_dst, instr_retired);
        end
        tick();
    endtask

    task automatic test_halt();
        opcode = 6'b111111; run = 1'b1;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            run = i[0];
            #1;
            n_checks++;
            if (state !== 4'd14 || illegal !== 1'b1 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
                n_fail++; $display("FAIL halt_hold cyc=%0d got st=%0d ill=%b pw=%b iw=%b exp 14/1/0/0", i, state, illegal, pc_write, ir_write);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset got st=%0d ill=%b exp 0/0", state, illegal);
        end
    endtask

    task automatic test_reset_midinstr();
        logic saw_rw;
        logic saw_ret;
        saw_rw = 1'b0; saw_ret = 1'b0;
        opcode = 6'b100011; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            saw_rw |= reg_write; saw_ret |= instr_retired;
            tick();
        end
        n_checks++;
        if (state !== 4'd3) begin
            n_fail++; $display("FAIL mid_memrd got=%0d exp=3", state);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0;
        n_checks++;
        if (state !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset got=%0d exp=0", state);
        end
        for (int i = 0; i < 4; i++) begin
            saw_rw |= reg_write; saw_ret |= instr_retired;
            tick();
        end
        n_checks++;
        if (saw_rw !== 1'b0 || saw_ret !== 1'b0 || state !== 4'd0) begin
            n_fail++; $display("FAIL mid_no_commit got rw=%b ret=%b st=%0d exp 0/0/0", saw_rw, saw_ret, state);
        end
    endtask

    task automatic test_run_drop();
        opcode = 6'b100011; run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick();
        n_checks++;
        if (state !== 4'd3) begin
            n_fail++; $display("FAIL drop_continue got=%0d exp=3", state);
        end
        tick();
        n_checks++;
        if (state !== 4'd4 || reg_write !== 1'b1) begin
            n_fail++; $display("FAIL drop_wb got st=%0d rw=%b exp 4/1", state, reg_write);
        end
        tick(); tick(); tick();
        n_checks++;
        if (state !== 4'd0 || ir_write !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle got st=%0d iw=%b exp 0/0", state, ir_write);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        test_reset();
        test_lw();
        test_sw_rtype();
        test_branch_jumps();
        test_halt();
        test_reset_midinstr();
        test_run_drop();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control sequencer for the 32-bit MIPS-subset CPU. It replaces the single-cycle combinational control so one shared ALU and one unified memory port serve every instruction over 3–5 cycles. It takes the latched opcode/funct and the ALU zero flag, and drives the per-cycle mux selects and write strobes of the multi-cycle datapath. ALU function selection is delegated to the existing ALU decoder through a 2-bit `alu_op`.

## Interface
- No parameters (opcode set and state encoding are fixed).
- `CLK` in 1: single system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `run` in 1: start/continue enable; sampled only in FETCH.
- `opcode` in 6: instruction register bits [31:26].
- `funct` in 6: instruction register bits [5:0].
- `zero` in 1: ALU zero flag; qualified by `pc_write_cond` inside the datapath.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if `zero` (beq).
- `ir_write` out 1: instruction register load.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `mem_to_reg` out 1: writeback data select; 0 = ALUOut, 1 = MDR.
- `reg_dst` out 1: destination select; 0 = rt, 1 = rd.
- `reg_write` out 1: register file write strobe.
- `jal_link` out 1: forces write register to 31 and write data to PC.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B select; 00 = B register, 01 = 4, 10 = signimm, 11 = signimm<<2.
- `alu_op` out 2: to the ALU decoder; 00 = add, 01 = sub, 10 = use funct.
- `pc_source` out 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], instr[25:0], 2'b00}, 11 = A register (jr).
- `instr_retired` out 1: one-cycle pulse in the final state of each instruction.
- `illegal` out 1: high while in HALT.
- `state` out 4: current state encoding, for debug.

## Operation
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7
  - BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, JALWB=12, JR=13, HALT=14
  - Encoding 15 is unreachable; if reached, go to HALT.
- Moore outputs, decoded from `state` only. Every output not listed for a state is 0.
  - FETCH: `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00, `ir_write`=`run`, `pc_write`=`run`. This is the only output gated by an input.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Precomputes the branch target into ALUOut.
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEMRD: `iord`=1.
  - MEMWB: `mem_to_reg`=1, `reg_dst`=0, `reg_write`=1.
  - MEMWR: `iord`=1, `mem_write`=1.
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - ALUWB: `reg_dst`=1, `reg_write`=1.
  - ADDIWB: `reg_dst`=0, `reg_write`=1.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write_cond`=1.
  - JUMP: `pc_source`=10, `pc_write`=1.
  - JALWB: `pc_source`=10, `pc_write`=1, `jal_link`=1, `reg_write`=1. The link value is PC, already incremented in FETCH.
  - JR: `pc_source`=11, `pc_write`=1.
  - HALT: `illegal`=1.
- Transitions:
  - FETCH→DECODE if `run`, else stay in FETCH.
  - DECODE dispatch on `opcode`:
    - 100011 (lw) → MEMADR
    - 101011 (sw) → MEMADR
    - 000000 with `funct`=001000 (jr) → JR
    - 000000 with any other `funct` → EXEC
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - 000011 (jal) → JALWB
    - any other opcode → HALT
  - MEMADR→MEMRD for lw, →MEMWR for sw. `opcode` is re-examined; the IR is stable.
  - MEMRD→MEMWB; EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP, JALWB and JR all → FETCH.
  - HALT→HALT until `rst`.
- `instr_retired` is 1 in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP, JALWB and JR. It pulses whether or not a beq is taken.

## Timing
- `rst` high at a rising edge puts the state in FETCH at that edge, from any state including mid-instruction and HALT. No partially completed strobes repeat.
- Outputs during and after reset are the FETCH values: `ir_write`/`pc_write` follow `run`, all other strobes are 0, and `state`=0.
- `rst` has priority over `run` and over every transition.
- Cycles per instruction, counting FETCH:
  - lw 5
  - sw, R-type and addi 4
  - beq, j, jal and jr 3
- Writes take effect at the rising edge ending the state that asserts them.
- `run` deasserted mid-instruction does not stall. The instruction completes and the FSM then idles in FETCH.
- `zero` is never registered here.

## Test plan
- Reset with `run`=0 for 3 cycles → `state`=0, `pc_write`=`ir_write`=0 and all strobes 0. Raise `run` → next cycle `state`=1.
- lw (`opcode`=100011), `run`=1 → states 0,1,2,3,4, then 0.
  - MEMRD has `iord`=1.
  - MEMWB has `mem_to_reg`=1 and `reg_write`=1.
  - `instr_retired` is high only in the 5th cycle.
- sw, then R-type add (`funct`=100000) → sw: states 0,1,2,5 with `mem_write`=1 only in state 5. add: states 0,1,6,7 with `alu_op`=10 in state 6 and `reg_dst`=1 in state 7.
- beq with `zero`=0, then jal, then jr (000000/001000):
  - beq: state 8 with `pc_write_cond`=1 and `pc_write`=0.
  - jal: state 12 with `jal_link`=`reg_write`=`pc_write`=1 and `pc_source`=10.
  - jr: state 13 with `pc_source`=11.
  - Each takes 3 cycles.
- `opcode`=111111 → state 14 with `illegal`=1, held for 10 cycles regardless of `run`. Assert `rst` → `state`=0 next cycle.
- Assert `rst` during MEMRD of a lw → next state 0, `reg_write` never asserted for that lw, and `instr_retired` never pulsed.
